// File: rtl/stepper_move_engine.sv
// -----------------------------------------------------------------------------
// stepper_move_engine
//
// Runs one motion command at a time for a stepper motor. A command is a
// full-step move, a half-step move or a timed pause. Each step is followed by
// a programmable wait, and the engine keeps the absolute motor position.
//
// Command handshake: start is a request that is accepted only while the
// engine is idle (busy=0, done=0). Accepting it captures mode, count and
// delay in that same cycle. start has no effect in any other state, so the
// requester must hold or re-issue it until the engine is idle. Every accepted
// command ends with exactly one done pulse.
//
// Ports
//   clk             : clock; all state changes on the rising edge
//   reset           : asynchronous, active-high reset
//   start           : command request, sampled only while idle
//   mode[1:0]       : 00 full-step, 01 half-step, 10 pause, 11 reserved
//   count[CNT_W]    : signed step count (negative = reverse)
//   delay[DLY_W]    : wait cycles after each step or for the pause
//   abort           : ends the active command at the next edge
//   clear_pos       : zeroes the position while idle
//   busy            : command in progress (STEP or WAIT)
//   done            : one-cycle completion pulse
//   step_pulse      : one-cycle pulse for each motor step
//   dir             : direction of the last step (0 fwd, 1 rev)
//   position[POS_W] : current motor position, wraps modulo 2^POS_W
//   steps_remaining : signed steps still to issue
// -----------------------------------------------------------------------------
module stepper_move_engine #(
    parameter int CNT_W = 8,
    parameter int POS_W = 8,
    parameter int DLY_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic signed [CNT_W-1:0] count,
    input  logic [DLY_W-1:0]        delay,
    input  logic                    abort,
    input  logic                    clear_pos,
    output logic                    busy,
    output logic                    done,
    output logic                    step_pulse,
    output logic                    dir,
    output logic [POS_W-1:0]        position,
    output logic signed [CNT_W-1:0] steps_remaining
);

    localparam logic [1:0] MODE_FULL  = 2'b00;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [DLY_W-1:0]        delay_q, delay_d;
    logic [DLY_W-1:0]        dly_cnt_q, dly_cnt_d;
    logic signed [CNT_W-1:0] steps_q, steps_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    step_fire;
    logic [POS_W-1:0]        pos_inc;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        delay_d   = delay_q;
        dly_cnt_d = dly_cnt_q;
        steps_d   = steps_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_fire = 1'b0;
        pos_inc   = (mode_q == MODE_FULL) ? POS_W'(2) : POS_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    steps_d = count;
                    delay_d = delay;
                    if (mode == MODE_PAUSE) begin
                        dly_cnt_d = delay;
                        state_d   = S_WAIT;
                    end else begin
                        state_d = S_STEP;
                    end
                end else if (clear_pos) begin
                    pos_d = '0;
                end
            end

            S_STEP: begin
                // abort wins over a step that would otherwise fire this cycle
                if (abort) begin
                    state_d = S_DONE;
                end else if (steps_q == '0 || mode_q == MODE_RSVD) begin
                    state_d = S_DONE;
                end else begin
                    step_fire = 1'b1;
                    dly_cnt_d = delay_q;
                    state_d   = S_WAIT;
                    // Counting toward zero from either side never overflows,
                    // so the most negative count is handled without negation.
                    if (steps_q[CNT_W-1]) begin
                        dir_d   = 1'b1;
                        pos_d   = pos_q - pos_inc;
                        steps_d = steps_q + CNT_W'(1);
                    end else begin
                        dir_d   = 1'b0;
                        pos_d   = pos_q + pos_inc;
                        steps_d = steps_q - CNT_W'(1);
                    end
                end
            end

            S_WAIT: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (dly_cnt_q == '0) begin
                    state_d = (mode_q == MODE_PAUSE) ? S_DONE : S_STEP;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            delay_q   <= '0;
            dly_cnt_q <= '0;
            steps_q   <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            delay_q   <= delay_d;
            dly_cnt_q <= dly_cnt_d;
            steps_q   <= steps_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
        end
    end

    // Status outputs decode the state register directly, so reset clears
    // them as soon as it is asserted, without waiting for a clock edge.
    assign busy            = (state_q == S_STEP) || (state_q == S_WAIT);
    assign done            = (state_q == S_DONE);
    assign step_pulse      = step_fire;
    assign dir             = dir_q;
    assign position        = pos_q;
    assign steps_remaining = steps_q;

endmodule

// File: doc/stepper_move_engine.md
STEPPER_MOVE_ENGINE -- requirements
Module: stepper_move_engine

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the signed step count.
REQ-002 The block SHALL have parameter POS_W, default 8, giving the width of the unsigned position register.
REQ-003 The block SHALL have parameter DLY_W, default 8, giving the width of the unsigned inter-step delay.
REQ-004 The block SHALL have these ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled in IDLE only.
- mode  in  2  00 full-step, 01 half-step, 10 pause, 11 reserved.
- count  in  CNT_W  signed step count, two's complement.
- delay  in  DLY_W  wait cycles after each step or pause.
- abort  in  1  terminate the active command.
- clear_pos  in  1  zero the position while IDLE.
- busy  out  1  command in progress (STEP or WAIT).
- done  out  1  one-cycle completion pulse.
- step_pulse  out  1  one-cycle pulse per motor step.
- dir  out  1  direction of the last step: 0 = forward, 1 = reverse.
- position  out  POS_W  current motor position.
- steps_remaining  out  CNT_W  signed steps still to issue.

Function
REQ-005 The FSM SHALL have four states: IDLE, STEP, WAIT and DONE.
REQ-006 In IDLE with start=1, the block SHALL capture mode, count and delay into internal registers.
- steps_remaining SHALL load count.
- Next state SHALL be WAIT for mode 10, with the delay counter loaded with delay.
- Next state SHALL be STEP for any other mode.
REQ-007 start SHALL be ignored in STEP, WAIT and DONE.
REQ-008 In IDLE with start=0 and clear_pos=1, position SHALL become 0 on the next edge. clear_pos SHALL be ignored in all other states and when start=1.
REQ-009 In STEP with steps_remaining=0, or with captured mode 11, the block SHALL go to DONE with no step.
REQ-010 In STEP with steps_remaining>0, the block SHALL do all of the following:
- assert step_pulse for that cycle;
- set dir=0;
- add the increment to position (2 for full-step, 1 for half-step);
- decrement steps_remaining;
- load the delay counter with the captured delay;
- go to WAIT.
REQ-011 In STEP with steps_remaining<0, the behaviour SHALL be as REQ-010, except that dir=1, position is decreased by the increment and steps_remaining is incremented.
REQ-012 In WAIT, when the delay counter is 0 the block SHALL leave WAIT: to STEP for move modes, to DONE for pause. Otherwise the counter SHALL decrement. WAIT therefore lasts delay+1 cycles, and the step period is delay+2 cycles.
REQ-013 position SHALL wrap modulo 2^POS_W in both directions.
REQ-014 count = -2^(CNT_W-1) SHALL be handled without overflow: it counts up to 0 correctly.
REQ-015 abort=1 in STEP or WAIT SHALL force DONE on the next edge.
- abort SHALL have priority over a step in the same cycle: no step_pulse, and position and steps_remaining unchanged.
- After an abort, steps_remaining SHALL hold the unissued count.
REQ-016 abort SHALL be ignored in IDLE and DONE.
REQ-017 In DONE, done SHALL be 1 and busy 0 for exactly one cycle, then the state SHALL return to IDLE.
REQ-018 busy SHALL be 1 exactly in STEP and WAIT. step_pulse SHALL be 1 only in STEP cycles that issue a step.
REQ-019 dir and position SHALL hold their values between commands.

Reset
REQ-020 reset=1 SHALL immediately, without a clock edge, force the following, from any state including mid-command:
- state = IDLE;
- busy = 0, done = 0, step_pulse = 0, dir = 0;
- position = 0;
- steps_remaining = 0;
- delay counter and captured registers = 0.
REQ-021 After reset deasserts, the first start SHALL be honoured on the first rising edge at which reset=0.

Verification
REQ-022 Full-step: position=0, mode=00, count=3, delay=2, start at cycle 0 -> step_pulse at cycles 1, 5 and 9; position 2, 4, 6; dir=0; done at cycle 14; steps_remaining=0.
REQ-023 Half-step reverse with wrap: position=1, mode=01, count=-2, delay=0 -> step_pulse at cycles 1 and 3; position 0 then 255; dir=1; done at cycle 6.
REQ-024 Zero count and reserved mode: count=0 with mode=00, and separately any count with mode=11 -> no step_pulse; done at cycle 2; position unchanged.
REQ-025 Pause: mode=10, delay=5 -> busy during cycles 1-6; done at cycle 7; no step_pulse; position unchanged.
REQ-026 Abort: mode=00, count=5, delay=3, with abort=1 in the WAIT after the second step -> done on the next cycle; position=4; steps_remaining=3; no further step_pulse.
REQ-027 Reset and ignored start: start pulsed while busy -> ignored; reset asserted mid-WAIT -> all outputs 0 asynchronously, before the next edge; a new command after release behaves as in REQ-022.
